// File: rtl/down_timer_pkg.sv
// Shared constants and state encoding for the down_timer block.
package down_timer_pkg;

    localparam int DT_WIDTH      = 8;
    localparam int DT_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_timer_prescaler.sv
// Step prescaler for down_timer: emits one tick every (prescale+1) enabled cycles.
// Only instantiated when DOWN_TIMER_PRESCALE_EN is defined.
module down_timer_prescaler
    import down_timer_pkg::*;
#(
    parameter int PRESCALE_W = DT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;

    // >= rather than == so a prescale lowered mid-interval still fires at once.
    assign tick = enable && (cnt_q >= prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer, one-shot or auto-reload, with registered tc pulse.
// Optional step prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | no run active, count 0, accepting loads
// ST_RUN  | counting down on enabled steps, loads refused
// ST_DONE | one-shot expired, count 0, accepting loads
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH      = DT_WIDTH,
    parameter int PRESCALE_W = DT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  periodic,
    input  logic                  enable,
    input  logic                  abort,
`ifdef DOWN_TIMER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (WIDTH < 2 || PRESCALE_W < 1) begin : g_param_check
        $error("down_timer: WIDTH must be >= 2 and PRESCALE_W >= 1");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] reload_q, reload_nxt;
    logic             mode_q, mode_nxt;
    logic             tc_q, tc_nxt;
    logic             accept;
    logic             tick;
    logic             step;

    assign load_ready = (state != ST_RUN);
    assign accept     = load_valid && load_ready;

`ifdef DOWN_TIMER_PRESCALE_EN
    down_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept || abort),
        .enable   (enable && (state == ST_RUN)),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign step = enable && tick;

    always_comb begin
        state_nxt  = state;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        mode_nxt   = mode_q;
        tc_nxt     = 1'b0;
        case (state)
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end else if (step) begin
                    if (count_q > ONE) begin
                        count_nxt = count_q - ONE;
                    end else begin
                        tc_nxt = 1'b1;
                        if (mode_q) begin
                            count_nxt = reload_q;
                        end else begin
                            count_nxt = '0;
                            state_nxt = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                if (accept) begin
                    reload_nxt = load_value;
                    count_nxt  = load_value;
                    if (load_value == '0) begin
                        // a zero-length run expires immediately and never reloads
                        state_nxt = ST_DONE;
                        mode_nxt  = 1'b0;
                        tc_nxt    = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                        mode_nxt  = periodic;
                    end
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count_q  <= count_nxt;
            reload_q <= reload_nxt;
            mode_q   <= mode_nxt;
            tc_q     <= tc_nxt;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: step-count model compared every cycle plus directed literal checks.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_value = '0;
    logic       periodic = 1'b0;
    logic       enable = 1'b1;
    logic       abort = 1'b0;
    logic [7:0] count;
    logic       tc;
    logic       busy;
    logic       done;
`ifdef DOWN_TIMER_PRESCALE_EN
    logic [3:0] prescale = '0;
`endif

    int checks = 0;
    int errors = 0;
    int tc_hits = 0;

    down_timer dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .periodic   (periodic),
        .enable     (enable),
        .abort      (abort),
`ifdef DOWN_TIMER_PRESCALE_EN
        .prescale   (prescale),
`endif
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0=idle 1=running 2=expired; count derived from steps taken since load.
    int m_phase = 0;
    int m_reload = 0;
    int m_per = 0;
    int m_steps = 0;
    int m_tc = 0;

    function automatic int exp_count();
        if (m_phase != 1) return 0;
        if (m_per != 0) return m_reload - (m_steps % m_reload);
        return m_reload - m_steps;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_reload <= 0; m_per <= 0; m_steps <= 0; m_tc <= 0;
        end else begin
            m_tc <= 0;
            if (m_phase != 1) begin
                if (load_valid) begin
                    m_reload <= int'(load_value);
                    m_steps  <= 0;
                    if (load_value == 0) begin
                        m_phase <= 2; m_per <= 0; m_tc <= 1;
                    end else begin
                        m_phase <= 1; m_per <= int'(periodic);
                    end
                end else if (abort) begin
                    m_phase <= 0; m_reload <= 0; m_steps <= 0;
                end
            end else if (abort) begin
                m_phase <= 0; m_reload <= 0; m_steps <= 0;
            end else if (enable) begin
                m_steps <= m_steps + 1;
                if (m_per != 0) begin
                    m_tc <= ((m_steps + 1) % m_reload == 0) ? 1 : 0;
                end else if (m_steps + 1 == m_reload) begin
                    m_phase <= 2; m_tc <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_count", count, exp_count());
            chk("cmp_tc", tc, m_tc);
            chk("cmp_busy", busy, m_phase == 1);
            chk("cmp_done", done, m_phase == 2);
            chk("cmp_ready", load_ready, m_phase != 1);
            if (tc) tc_hits++;
        end
    end

    task automatic do_load(input logic [7:0] v, input logic per);
        load_valid = 1'b1;
        load_value = v;
        periodic   = per;
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic do_abort();
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
    endtask

    int ex1 [4] = '{3, 2, 1, 0};
    int tc1 [4] = '{0, 0, 0, 1};
    int ex2 [9] = '{4, 3, 2, 1, 4, 3, 2, 1, 4};
    int tc2 [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    int tc3 [4] = '{0, 1, 1, 1};
    int en4 [5] = '{1, 0, 0, 1, 1};
    int ex4 [6] = '{3, 2, 2, 2, 1, 0};
    int ex5 [4] = '{5, 4, 3, 2};
    int tc_before;

    initial begin
        #2;
        chk("rst_count", count, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tc", tc, 0);
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // one-shot, load 3
        do_load(8'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("os_count", count, ex1[i]);
            chk("os_tc", tc, tc1[i]);
        end
        @(negedge clk);
        chk("os_done", done, 1);
        chk("os_busy", busy, 0);
        chk("os_ready", load_ready, 1);
        chk("os_tc_after", tc, 0);

        // periodic, load 4
        #1 do_load(8'd4, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("per_count", count, ex2[i]);
            chk("per_tc", tc, tc2[i]);
        end
        do_abort();
        @(negedge clk);
        chk("per_abort_busy", busy, 0);
        chk("per_abort_count", count, 0);

        // periodic, load 1: tc every cycle after the first
        #1 do_load(8'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("p1_count", count, 1);
            chk("p1_tc", tc, tc3[i]);
        end
        do_abort();

        // enable pattern 1,0,0,1,1
        do_load(8'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            enable = (i < 5) ? en4[i][0] : 1'b1;
            @(negedge clk);
            chk("en_count", count, ex4[i]);
            chk("en_tc", tc, (i == 5) ? 1 : 0);
            @(posedge clk); #1;
        end
        enable = 1'b1;

        // load 5, refused load while busy, abort at count 2
        tc_before = tc_hits;
        do_load(8'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ab_count", count, ex5[i]);
            if (i == 1) begin
                #1 load_valid = 1'b1; load_value = 8'd9;
            end
            if (i == 2) begin
                #1 load_valid = 1'b0;
            end
        end
        do_abort();
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_count_zero", count, 0);
        chk("ab_done", done, 0);
        chk("ab_no_tc", tc_hits - tc_before, 0);

        // reset mid-run at count 3, then load 0
        #1 do_load(8'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rr_count", count, ex5[i]);
        end
        #1 reset = 1'b1;
        #1;
        chk("rr_count_zero", count, 0);
        chk("rr_busy", busy, 0);
        chk("rr_ready", load_ready, 1);
        chk("rr_done", done, 0);
        #2 reset = 1'b0;
        do_load(8'd0, 1'b1);
        @(negedge clk);
        chk("z_done", done, 1);
        chk("z_tc", tc, 1);
        chk("z_busy", busy, 0);
        chk("z_count", count, 0);
        @(negedge clk);
        chk("z_tc_once", tc, 0);
        chk("z_done_hold", done, 1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
